m68k_bus_cycle: RTL



---
 rtl/m68k_bus_cycle_pkg.sv | 47 ++++
 rtl/m68k_bus_cycle_if.sv | 42 ++++
 rtl/m68k_bus_cycle.sv | 133 +++++++++++++
 3 files changed

// File: rtl/m68k_bus_cycle_pkg.sv
// Shared types for the MC68000 bus-cycle engine: the state encoding, the FC codes
// and the registered state bundle that the two-process FSM carries.
package m68k_bus_pkg;

  typedef enum logic [3:0] {
    IDLE, S0, S1, S2, S3, S4, S5, S6, S7
  } bus_state_e;

  localparam logic [2:0] USER_DATA  = 3'd1;
  localparam logic [2:0] USER_PROG  = 3'd2;
  localparam logic [2:0] SUPER_DATA = 3'd5;
  localparam logic [2:0] SUPER_PROG = 3'd6;
  localparam logic [2:0] IACK       = 3'd7;

  // Every flop of the engine: the visible outputs plus the captured request.
  typedef struct packed {
    bus_state_e  state;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rdata;
    logic [7:0]  waits;
    logic        as_n;
    logic        uds_n;
    logic        lds_n;
    logic        rw;
    logic [2:0]  fc;
    logic [22:0] a;
    logic [15:0] d_out;
    logic        a_oe;
    logic        d_oe;
    logic        cap_rw;
    logic [22:0] cap_addr;
    logic [15:0] cap_wdata;
    logic        cap_uds;
    logic        cap_lds;
    logic [2:0]  cap_fc;
  } cyc_regs_t;

  localparam cyc_regs_t CYC_RST = '{
    state: IDLE, busy: 1'b0, done: 1'b0, err: 1'b0, rdata: 16'h0, waits: 8'h0,
    as_n: 1'b1, uds_n: 1'b1, lds_n: 1'b1, rw: 1'b1, fc: 3'd0, a: 23'h0,
    d_out: 16'h0, a_oe: 1'b0, d_oe: 1'b0, cap_rw: 1'b1, cap_addr: 23'h0,
    cap_wdata: 16'h0, cap_uds: 1'b0, cap_lds: 1'b0, cap_fc: 3'd0
  };

endpackage

// File: rtl/m68k_bus_cycle_if.sv
// Request/response and Amiga-side bus signals of the bus-cycle engine.
// slave = the engine, master = the Pi-side requester plus the synchronizer/bus model.
interface m68k_bus_cycle_if;
  logic        MCCLK_RISING;
  logic        MCCLK_FALLING;
  logic        DTACK_LATCH;
  logic        BERR_N;
  logic        REQ;
  logic        REQ_RW;
  logic [22:0] REQ_ADDR;
  logic [15:0] REQ_WDATA;
  logic        REQ_UDS;
  logic        REQ_LDS;
  logic [2:0]  REQ_FC;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [15:0] RDATA;
  logic [7:0]  WAITS;
  logic        AS_N;
  logic        UDS_N;
  logic        LDS_N;
  logic        RW;
  logic [2:0]  FC;
  logic [22:0] A;
  logic [15:0] D_OUT;
  logic [15:0] D_IN;
  logic        A_OE;
  logic        D_OE;

  modport slave (
    input  MCCLK_RISING, MCCLK_FALLING, DTACK_LATCH, BERR_N, REQ, REQ_RW, REQ_ADDR,
           REQ_WDATA, REQ_UDS, REQ_LDS, REQ_FC, D_IN,
    output BUSY, DONE, ERR, RDATA, WAITS, AS_N, UDS_N, LDS_N, RW, FC, A, D_OUT, A_OE, D_OE
  );

  modport master (
    output MCCLK_RISING, MCCLK_FALLING, DTACK_LATCH, BERR_N, REQ, REQ_RW, REQ_ADDR,
           REQ_WDATA, REQ_UDS, REQ_LDS, REQ_FC, D_IN,
    input  BUSY, DONE, ERR, RDATA, WAITS, AS_N, UDS_N, LDS_N, RW, FC, A, D_OUT, A_OE, D_OE
  );
endinterface

// File: rtl/m68k_bus_cycle.sv
// One MC68000 read/write bus cycle per request, paced by MCCLK edge strobes (S0-S7).
// `define M68K_BERR_EN makes BERR_N terminate S4 with ERR=1; otherwise BERR_N is ignored.
module m68k_bus_cycle
  import m68k_bus_pkg::*;
#(
  parameter int WAIT_LIMIT = 0
) (
  input  logic SYSCLK,
  input  logic SYSRST_N,
  m68k_bus_cycle_if.slave bus
);

  localparam logic [7:0] WLIM    = 8'(WAIT_LIMIT);
  localparam bit         WLIM_EN = (WAIT_LIMIT != 0);

  cyc_regs_t r, n;
  logic      rise, fall, berr;

  // Both strobes high at once is treated as no event.
  assign rise = bus.MCCLK_RISING & ~bus.MCCLK_FALLING;
  assign fall = bus.MCCLK_FALLING & ~bus.MCCLK_RISING;

`ifdef M68K_BERR_EN
  assign berr = ~bus.BERR_N;
`else
  logic berr_unused;
  assign berr_unused = bus.BERR_N;
  assign berr = 1'b0;
`endif

  always_ff @(negedge SYSCLK or negedge SYSRST_N) begin
    if (!SYSRST_N) r <= CYC_RST;
    else           r <= n;
  end

  always_comb begin
    n      = r;
    n.done = 1'b0;
    case (r.state)
      IDLE: ;
      S0: if (fall) begin
        n.state = S1;
        n.a_oe  = 1'b1;
        n.a     = r.cap_addr;
        n.fc    = r.cap_fc;
        n.rw    = r.cap_rw;
      end
      S1: if (rise) begin
        n.state = S2;
        n.as_n  = 1'b0;
        if (r.cap_rw) begin
          n.uds_n = ~r.cap_uds;
          n.lds_n = ~r.cap_lds;
        end
      end
      S2: if (fall) begin
        n.state = S3;
        if (!r.cap_rw) begin
          n.d_oe  = 1'b1;
          n.d_out = r.cap_wdata;
        end
      end
      S3: if (rise) begin
        n.state = S4;
        if (!r.cap_rw) begin
          n.uds_n = ~r.cap_uds;
          n.lds_n = ~r.cap_lds;
        end
      end
      // Wait states are counted per S4 falling strobe without a qualified DTACK.
      S4: if (fall) begin
        if (berr) begin
          n.state = S5;
          n.err   = 1'b1;
        end else if (bus.DTACK_LATCH) begin
          n.state = S5;
          n.err   = 1'b0;
        end else if (WLIM_EN && r.waits == WLIM) begin
          n.state = S5;
          n.err   = 1'b1;
        end else if (r.waits != 8'hFF) begin
          n.waits = r.waits + 8'd1;
        end
      end
      S5: if (rise) n.state = S6;
      S6: if (fall) begin
        n.state = S7;
        if (r.cap_rw) n.rdata = bus.D_IN;
        n.as_n  = 1'b1;
        n.uds_n = 1'b1;
        n.lds_n = 1'b1;
        n.done  = 1'b1;
      end
      S7: if (rise) begin
        n.state = IDLE;
        n.a_oe  = 1'b0;
        n.d_oe  = 1'b0;
        n.rw    = 1'b1;
        n.busy  = 1'b0;
      end
      default: n = CYC_RST;
    endcase

    // Acceptance from IDLE, or straight out of S7 on the same rising strobe.
    if (rise && bus.REQ && (r.state == IDLE || r.state == S7)) begin
      n.state     = S0;
      n.busy      = 1'b1;
      n.waits     = 8'h0;
      n.cap_rw    = bus.REQ_RW;
      n.cap_addr  = bus.REQ_ADDR;
      n.cap_wdata = bus.REQ_WDATA;
      n.cap_uds   = bus.REQ_UDS;
      n.cap_lds   = bus.REQ_LDS;
      n.cap_fc    = bus.REQ_FC;
    end
  end

  assign bus.BUSY  = r.busy;
  assign bus.DONE  = r.done;
  assign bus.ERR   = r.err;
  assign bus.RDATA = r.rdata;
  assign bus.WAITS = r.waits;
  assign bus.AS_N  = r.as_n;
  assign bus.UDS_N = r.uds_n;
  assign bus.LDS_N = r.lds_n;
  assign bus.RW    = r.rw;
  assign bus.FC    = r.fc;
  assign bus.A     = r.a;
  assign bus.D_OUT = r.d_out;
  assign bus.A_OE  = r.a_oe;
  assign bus.D_OE  = r.d_oe;

endmodule
